// File: rtl/unidad_fetch_if.sv
// Instruction-fetch bus bundle: memory read channel plus
// the valid/ready hand-off of the fetched word to the datapath.
interface unidad_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] instruccion;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data,
    output instruccion,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data,
    input  instruccion,
    input  inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/unidad_fetch.sv
// Fetch unit: IDLE/REQ/HOLD sequencer that reads one word at pc,
// hands it to the datapath and advances pc on acceptance.
module unidad_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  unidad_fetch_if.master   bus,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] contador,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } estado_t;

  estado_t     estado;
  estado_t     estado_n;
  logic [29:0] pc_w;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        captura;
  logic        acepta;

  always_comb begin
    estado_n = estado;
    captura  = 1'b0;
    acepta   = 1'b0;
    unique case (estado)
      IDLE: begin
        if (start && !halt)
          estado_n = REQ;
      end
      REQ: begin
        if (bus.mem_ack) begin
          captura  = 1'b1;
          estado_n = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && bus.inst_ready) begin
          acepta   = 1'b1;
          estado_n = halt ? IDLE : REQ;
        end
      end
      default: estado_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      estado <= IDLE;
    else
      estado <= estado_n;
  end

  // pc is kept as a word index so its low two bits are zero by construction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_w     <= RESET_PC[31:2];
      inst_q   <= '0;
      valid_q  <= 1'b0;
      contador <= '0;
    end else begin
      if (captura) begin
        inst_q  <= bus.mem_data;
        valid_q <= 1'b1;
      end
      if (acepta) begin
        valid_q <= 1'b0;
        pc_w    <= pc_w + 30'd1;
        if (contador != {CNT_W{1'b1}})
          contador <= contador + 1'b1;
      end
    end
  end

  assign pc              = {pc_w, 2'b00};
  assign bus.mem_req     = (estado == REQ);
  assign bus.mem_addr    = pc;
  assign bus.instruccion = inst_q;
  assign bus.inst_valid  = valid_q;
  assign busy            = (estado != IDLE);

endmodule

// File: tb/tb_unidad_fetch.sv
// Bench for unidad_fetch: directed latency/halt/reset cases
// followed by randomized traffic against a transaction scoreboard.
module tb_unidad_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic [31:0] pc;
  logic [15:0] cnt;
  logic        busy;
  logic [31:0] pc2;
  logic [1:0]  cnt2;
  logic        busy2;

  int n_chk = 0;
  int n_err = 0;
  int retardo = 0;
  int espera = 0;
  bit aleatorio = 1'b0;

  unidad_fetch_if mif ();
  unidad_fetch_if mif2 ();

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0022_1820;
  endfunction

  unidad_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .halt     (halt),
    .bus      (mif),
    .pc       (pc),
    .contador (cnt),
    .busy     (busy)
  );

  unidad_fetch #(
    .RESET_PC (32'hFFFF_FFF8),
    .CNT_W    (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .halt     (halt),
    .bus      (mif2),
    .pc       (pc2),
    .contador (cnt2),
    .busy     (busy2)
  );

  assign mif2.mem_ack    = mif2.mem_req;
  assign mif2.mem_data   = memfn(mif2.mem_addr);
  assign mif2.inst_ready = 1'b1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_mem();
    if (mif.mem_req) begin
      if (espera >= retardo) begin
        mif.mem_ack  = 1'b1;
        mif.mem_data = memfn(mif.mem_addr);
        espera = 0;
        if (aleatorio)
          retardo = $urandom_range(0, 3);
      end else begin
        mif.mem_ack  = 1'b0;
        mif.mem_data = $urandom;
        espera++;
      end
    end else begin
      espera = 0;
      mif.mem_ack  = aleatorio && ($urandom_range(0, 3) == 0);
      mif.mem_data = $urandom;
    end
  endtask

  task automatic paso();
    @(posedge clk);
    #1;
    drive_mem();
  endtask

  task automatic reinicio();
    rst = 1'b1;
    start = 1'b0;
    halt = 1'b0;
    mif.inst_ready = 1'b1;
    mif.mem_ack = 1'b0;
    mif.mem_data = '0;
    aleatorio = 1'b0;
    retardo = 0;
    espera = 0;
    #2;
    check("rst_pc", pc, 32'h0);
    check("rst_pc2", pc2, 32'hFFFF_FFF8);
    check("rst_valid", mif.inst_valid, 0);
    check("rst_instr", mif.instruccion, 0);
    check("rst_req", mif.mem_req, 0);
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        p_req, p_ack, p_valid, p_ready, p_halt, p_go, p_stay;
  logic [31:0] p_addr, p_data, p_word;

  initial begin
    // zero-wait fetch, 2-cycle throughput, wrap and saturation
    reinicio();
    start = 1'b1;
    check("idle_after_rst", mif.mem_req, 0);
    paso();
    check("c1_req", mif.mem_req, 1);
    check("c1_addr", mif.mem_addr, 32'h0);
    check("c1_busy", busy, 1);
    paso();
    check("c2_valid", mif.inst_valid, 1);
    check("c2_instr", mif.instruccion, 32'h0022_1820);
    check("c2_req", mif.mem_req, 0);
    paso();
    check("c3_pc", pc, 32'h4);
    check("c3_cnt", cnt, 1);
    check("c3_req", mif.mem_req, 1);
    check("c3_pc2", pc2, 32'hFFFF_FFFC);
    paso();
    paso();
    check("c5_cnt", cnt, 2);
    check("c5_pc", pc, 32'h8);
    check("c5_pc2_wrap", pc2, 32'h0);
    repeat (8) paso();
    check("c13_cnt", cnt, 6);
    check("cnt2_sat", cnt2, 2'd3);
    check("pc2_track", pc2, 32'hFFFF_FFF8 + 32'(cnt) * 4);
    halt = 1'b1;
    for (int i = 0; i < 10 && busy; i++) paso();
    check("halt_stop", busy, 0);

    // slow memory, then datapath stall
    reinicio();
    retardo = 3;
    start = 1'b1;
    paso();
    for (int i = 0; i < 3; i++) begin
      check("slow_req", mif.mem_req, 1);
      check("slow_addr", mif.mem_addr, 32'h0);
      check("slow_novalid", mif.inst_valid, 0);
      paso();
    end
    check("slow_req4", mif.mem_req, 1);
    mif.inst_ready = 1'b0;
    paso();
    retardo = 0;
    check("slow_valid", mif.inst_valid, 1);
    check("slow_instr", mif.instruccion, memfn(32'h0));
    for (int i = 0; i < 4; i++) begin
      paso();
      check("stall_valid", mif.inst_valid, 1);
      check("stall_instr", mif.instruccion, memfn(32'h0));
      check("stall_req", mif.mem_req, 0);
      check("stall_pc", pc, 32'h0);
    end
    mif.inst_ready = 1'b1;
    paso();
    check("stall_acc_pc", pc, 32'h4);
    check("stall_acc_valid", mif.inst_valid, 0);
    check("stall_acc_cnt", cnt, 1);
    check("stall_acc_req", mif.mem_req, 1);

    // halt raised while requesting at pc=8
    for (int i = 0; i < 12 && !(pc == 32'h8 && mif.mem_req); i++) paso();
    check("reach8_pc", pc, 32'h8);
    check("reach8_req", mif.mem_req, 1);
    halt = 1'b1;
    paso();
    check("halt_valid", mif.inst_valid, 1);
    check("halt_instr", mif.instruccion, memfn(32'h8));
    paso();
    check("halt_pc", pc, 32'hC);
    check("halt_cnt", cnt, 3);
    check("halt_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      paso();
      check("halt_wins_req", mif.mem_req, 0);
      check("halt_wins_busy", busy, 0);
    end

    // async reset in HOLD, stale ack ignored
    halt = 1'b0;
    mif.inst_ready = 1'b0;
    paso();
    paso();
    check("hold_valid", mif.inst_valid, 1);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", mif.inst_valid, 0);
    check("arst_pc", pc, 32'h0);
    check("arst_req", mif.mem_req, 0);
    check("arst_busy", busy, 0);
    #1;
    rst = 1'b0;
    mif.mem_ack = 1'b1;
    mif.mem_data = 32'hDEAD_BEEF;
    paso();
    check("late_ack_valid", mif.inst_valid, 0);
    check("late_ack_instr", mif.instruccion, 32'h0);
    for (int i = 0; i < 2; i++) begin
      paso();
      check("post_rst_idle", busy, 0);
    end

    // async reset in REQ
    mif.inst_ready = 1'b1;
    retardo = 5;
    start = 1'b1;
    paso();
    check("req_before_rst", mif.mem_req, 1);
    start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_req2", mif.mem_req, 0);
    #1;
    rst = 1'b0;
    mif.mem_ack = 1'b1;
    mif.mem_data = 32'hBAD0_0BAD;
    paso();
    check("late_ack2_busy", busy, 0);
    check("late_ack2_valid", mif.inst_valid, 0);

    // randomized traffic against the scoreboard
    reinicio();
    aleatorio = 1'b1;
    retardo = $urandom_range(0, 3);
    m_pc = 32'h0;
    m_cnt = 16'h0;
    p_req = 0; p_ack = 0; p_valid = 0; p_ready = 0;
    p_halt = 0; p_go = 0; p_stay = 0;
    p_addr = 0; p_data = 0; p_word = 0;
    for (int i = 0; i < 3000; i++) begin
      check("r_pc", pc, m_pc);
      check("r_align", pc[1:0], 0);
      check("r_cnt", cnt, m_cnt);
      check("r_excl", mif.mem_req & mif.inst_valid, 0);
      if (mif.mem_req)
        check("r_addr", mif.mem_addr, pc);
      if (p_req && !p_ack) begin
        check("r_req_held", mif.mem_req, 1);
        check("r_addr_held", mif.mem_addr, p_addr);
      end
      if (p_req && p_ack) begin
        check("r_cap_valid", mif.inst_valid, 1);
        check("r_cap_instr", mif.instruccion, p_data);
      end
      if (p_valid && !p_ready) begin
        check("r_stall_valid", mif.inst_valid, 1);
        check("r_stall_instr", mif.instruccion, p_word);
        check("r_stall_req", mif.mem_req, 0);
      end
      if (p_valid && p_ready) begin
        check("r_acc_valid", mif.inst_valid, 0);
        check("r_acc_req", mif.mem_req, !p_halt);
        check("r_acc_busy", busy, !p_halt);
      end
      if (p_go)
        check("r_go", mif.mem_req, 1);
      if (p_stay)
        check("r_stay", busy, 0);

      start = ($urandom_range(0, 7) != 0);
      halt = ($urandom_range(0, 15) == 0);
      mif.inst_ready = ($urandom_range(0, 3) != 0);

      if (mif.inst_valid && mif.inst_ready) begin
        check("r_acc_word", mif.instruccion, memfn(pc));
        m_pc = m_pc + 32'd4;
        if (m_cnt != 16'hFFFF)
          m_cnt = m_cnt + 16'd1;
      end

      p_req = mif.mem_req;
      p_ack = mif.mem_ack;
      p_addr = mif.mem_addr;
      p_data = mif.mem_data;
      p_valid = mif.inst_valid;
      p_ready = mif.inst_ready;
      p_word = mif.instruccion;
      p_halt = halt;
      p_go = !busy && start && !halt;
      p_stay = !busy && !(start && !halt);
      paso();
    end
    check("r_activity", m_cnt > 16'd100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
